// File: rtl/sample_scheduler_if.sv
// Handshake bundle between the sample scheduler (master) and the shared
// acquisition engine (slave).
interface sample_scheduler_if #(
    parameter int CH_W = 3
) ();
    logic            acq_req;
    logic [CH_W-1:0] acq_ch;
    logic            acq_ack;
    logic            acq_done;

    modport master (output acq_req, output acq_ch, input acq_ack, input acq_done);
    modport slave  (input acq_req, input acq_ch, output acq_ack, output acq_done);
endinterface

// File: rtl/sample_scheduler.sv
// Grants one shared acquisition engine to NCH periodic sample sources, with
// per-channel overrun counters and a BUSY watchdog.
// Optional macro SAMPLE_SCHED_RR_EN: round-robin arbitration instead of fixed priority.
module sample_scheduler #(
    parameter int NCH     = 5,
    parameter int CH_W    = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_en,
    input  logic [NCH-1:0]        tick_in,
    sample_scheduler_if.master    acq,
    output logic                  busy,
    output logic [NCH-1:0]        pending,
    input  logic [CH_W-1:0]       ovr_sel,
    output logic [CNT_W-1:0]      ovr_cnt,
    input  logic                  ovr_clr,
    output logic                  timeout_err
);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

    state_t            r_state, w_state_next;
    logic              r_req;
    logic [CH_W-1:0]   r_ch;
    logic              r_busy;
    logic              r_terr;
    logic [TO_W-1:0]   r_tmo, w_tmo_next;
    logic [NCH-1:0]    r_tick_d;
    logic [NCH-1:0]    w_pending;
    logic [CNT_W-1:0]  w_ovr [NCH];
    logic [CH_W-1:0]   w_winner;
    logic              w_grant;
    logic              w_tmo_fire;

    // Per-channel pending flag and saturating overrun counter.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic             r_pend;
            logic [CNT_W-1:0] r_cnt;
            logic             w_edge, w_gnt, w_inc, w_clr;

            assign w_edge = tick_in[gi] & ~r_tick_d[gi];
            assign w_gnt  = w_grant && (r_ch == CH_W'(gi));
            assign w_inc  = ch_en[gi] & w_edge & r_pend & ~w_gnt;
            assign w_clr  = ovr_clr && (ovr_sel == CH_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pend <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    if (!ch_en[gi])
                        r_pend <= 1'b0;
                    else if (w_gnt)
                        r_pend <= w_edge;
                    else if (w_edge)
                        r_pend <= 1'b1;

                    if (w_clr)
                        r_cnt <= w_inc ? CNT_W'(1) : '0;
                    else if (w_inc && (r_cnt != '1))
                        r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_pending[gi] = r_pend;
            assign w_ovr[gi]     = r_cnt;
        end
    endgenerate

`ifdef SAMPLE_SCHED_RR_EN
    logic [CH_W-1:0] r_rr_ptr;

    always_comb begin
        int  idx;
        logic found;
        w_winner = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(r_rr_ptr) + k) % NCH;
            if (!found && w_pending[idx]) begin
                w_winner = CH_W'(idx);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr_ptr <= '0;
        else if (w_grant)
            r_rr_ptr <= (r_ch == CH_W'(NCH - 1)) ? '0 : r_ch + 1'b1;
    end
`else
    always_comb begin
        w_winner = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_pending[k])
                w_winner = CH_W'(k);
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_tmo_next   = r_tmo;
        w_grant      = 1'b0;
        w_tmo_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_pending)
                    w_state_next = S_REQ;
            end
            S_REQ: begin
                // An ack in the same cycle as a disable still wins the grant.
                if (acq.acq_ack) begin
                    w_state_next = S_BUSY;
                    w_tmo_next   = '0;
                    w_grant      = 1'b1;
                end else if (!ch_en[r_ch]) begin
                    w_state_next = S_IDLE;
                end
            end
            S_BUSY: begin
                if (acq.acq_done) begin
                    w_state_next = S_IDLE;
                end else if (r_tmo == TO_LAST) begin
                    w_state_next = S_IDLE;
                    w_tmo_fire   = 1'b1;
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_ch     <= '0;
            r_busy   <= 1'b0;
            r_terr   <= 1'b0;
            r_tmo    <= '0;
            r_tick_d <= '0;
        end else begin
            r_state  <= w_state_next;
            r_req    <= (w_state_next == S_REQ);
            r_busy   <= (w_state_next != S_IDLE);
            r_terr   <= w_tmo_fire;
            r_tmo    <= w_tmo_next;
            r_tick_d <= tick_in;
            if (r_state == S_IDLE && w_state_next == S_REQ)
                r_ch <= w_winner;
        end
    end

    always_comb begin
        ovr_cnt = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ovr_sel == CH_W'(k))
                ovr_cnt = w_ovr[k];
        end
    end

    assign acq.acq_req  = r_req;
    assign acq.acq_ch   = r_ch;
    assign busy         = r_busy;
    assign pending      = w_pending;
    assign timeout_err  = r_terr;

endmodule

// File: tb/tb_sample_scheduler.sv
// Randomized and directed bench for sample_scheduler, checked every cycle
// against a behavioural model of the scheduling rules.
module tb_sample_scheduler;
    localparam int NCH = 5;
    localparam int CH_W = 3;
    localparam int CNT_W = 8;
    localparam int TIMEOUT = 1000;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_BUSY = 2;
`ifdef SAMPLE_SCHED_RR_EN
    localparam int FIRST = 3, SECOND = 1;
`else
    localparam int FIRST = 1, SECOND = 3;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   ch_en = '0;
    logic [NCH-1:0]   tick_in = '0;
    logic             busy;
    logic [NCH-1:0]   pending;
    logic [CH_W-1:0]  ovr_sel = '0;
    logic [CNT_W-1:0] ovr_cnt;
    logic             ovr_clr = 1'b0;
    logic             timeout_err;

    int n_chk = 0;
    int n_fail = 0;

    sample_scheduler_if #(.CH_W(CH_W)) acq_if ();

    sample_scheduler #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .tick_in(tick_in), .acq(acq_if),
        .busy(busy), .pending(pending), .ovr_sel(ovr_sel), .ovr_cnt(ovr_cnt),
        .ovr_clr(ovr_clr), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int           m_phase, m_ch, m_rr, m_busy_cycles;
    bit [NCH-1:0] m_pend, m_tick_d;
    int           m_cnt [NCH];
    bit           m_terr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit [NCH-1:0] p, input int start);
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (start + k) % NCH;
            if (p[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_ch = 0; m_rr = 0; m_busy_cycles = 0;
        m_pend = '0; m_tick_d = '0; m_terr = 0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        bit [NCH-1:0] edg, old_p;
        bit grant;
        edg = tick_in & ~m_tick_d;
        old_p = m_pend;
        m_tick_d = tick_in;
        grant = (m_phase == PH_REQ) && acq_if.acq_ack;
        m_terr = 0;
        for (int i = 0; i < NCH; i++) begin
            bit mine, inc;
            mine = grant && (m_ch == i);
            inc = ch_en[i] && edg[i] && old_p[i] && !mine;
            if (!ch_en[i]) m_pend[i] = 0;
            else if (mine) m_pend[i] = edg[i];
            else if (edg[i]) m_pend[i] = 1;
            if (ovr_clr && ovr_sel == i) m_cnt[i] = inc ? 1 : 0;
            else if (inc && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
        end
        case (m_phase)
            PH_IDLE: if (old_p != 0) begin
`ifdef SAMPLE_SCHED_RR_EN
                m_ch = pick(old_p, m_rr);
`else
                m_ch = pick(old_p, 0);
`endif
                m_phase = PH_REQ;
            end
            PH_REQ: if (grant) begin
                m_phase = PH_BUSY; m_busy_cycles = 0; m_rr = (m_ch + 1) % NCH;
            end else if (!ch_en[m_ch]) m_phase = PH_IDLE;
            default: begin
                m_busy_cycles++;
                if (acq_if.acq_done) m_phase = PH_IDLE;
                else if (m_busy_cycles == TIMEOUT) begin m_terr = 1; m_phase = PH_IDLE; end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("acq_req", 32'(acq_if.acq_req), 32'(m_phase == PH_REQ));
        chk("acq_ch", 32'(acq_if.acq_ch), 32'(m_ch));
        chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("ovr_cnt", 32'(ovr_cnt), (ovr_sel < NCH) ? 32'(m_cnt[ovr_sel]) : 32'd0);
    end

    task automatic cleanup();
        ch_en = '0; tick_in = '0; ovr_clr = 0; acq_if.acq_ack = 0; acq_if.acq_done = 1;
        step();
        acq_if.acq_done = 0;
        step(); step();
    endtask

    task automatic pulse_tick(input int ch);
        tick_in[ch] = 1'b1; step();
        tick_in[ch] = 1'b0; step();
    endtask

    int half [NCH];
    int hcnt [NCH];
    int seen;
    int pulses;

    initial begin
        acq_if.acq_ack = 0;
        acq_if.acq_done = 0;
        model_reset();
        #1;
        chk("reset_req", 32'(acq_if.acq_req), 0);
        chk("reset_busy", 32'(busy), 0);
        step(); step();
        rst = 0;
        step();

        // Single channel
        ch_en = 5'b00001;
        step();
        tick_in[0] = 1; step();
        chk("single_pend", 32'(pending), 32'h1);
        chk("single_req_early", 32'(acq_if.acq_req), 0);
        tick_in[0] = 0; step();
        chk("single_req", 32'(acq_if.acq_req), 1);
        chk("single_ch", 32'(acq_if.acq_ch), 0);
        step();
        acq_if.acq_ack = 1; step(); acq_if.acq_ack = 0;
        chk("single_ack_req", 32'(acq_if.acq_req), 0);
        chk("single_ack_busy", 32'(busy), 1);
        repeat (5) step();
        chk("single_busy_held", 32'(busy), 1);
        acq_if.acq_done = 1; step(); acq_if.acq_done = 0;
        chk("single_done_busy", 32'(busy), 0);
        chk("single_done_pend", 32'(pending), 0);
        cleanup();

        // Contention after a ch2 grant
        ch_en = 5'b11111;
        pulse_tick(2);
        chk("pre_ch", 32'(acq_if.acq_ch), 2);
        acq_if.acq_ack = 1; step(); acq_if.acq_ack = 0;
        acq_if.acq_done = 1; step(); acq_if.acq_done = 0;
        tick_in = 5'b01010; step();
        chk("cont_pend", 32'(pending), 32'h0a);
        tick_in = '0; step();
        chk("cont_first", 32'(acq_if.acq_ch), FIRST);
        acq_if.acq_ack = 1; step(); acq_if.acq_ack = 0;
        acq_if.acq_done = 1; step(); acq_if.acq_done = 0;
        chk("cont_gap_req", 32'(acq_if.acq_req), 0);
        step();
        chk("cont_second_req", 32'(acq_if.acq_req), 1);
        chk("cont_second", 32'(acq_if.acq_ch), SECOND);
        cleanup();

        // Overrun and saturation
        ch_en = 5'b00001; ovr_sel = 0;
        for (int r = 0; r < 3; r++) pulse_tick(0);
        chk("ovr_two", 32'(ovr_cnt), 2);
        chk("ovr_pend", 32'(pending[0]), 1);
        for (int r = 0; r < 260; r++) pulse_tick(0);
        chk("ovr_sat", 32'(ovr_cnt), 255);
        tick_in[0] = 1; ovr_clr = 1; step();
        chk("ovr_clr_edge", 32'(ovr_cnt), 1);
        tick_in[0] = 0; step();
        chk("ovr_clr_only", 32'(ovr_cnt), 0);
        ovr_clr = 0;
        cleanup();

        // Withdraw
        ch_en = 5'b00100;
        pulse_tick(2);
        chk("wd_req", 32'(acq_if.acq_req), 1);
        ch_en = '0; step();
        chk("wd_req_drop", 32'(acq_if.acq_req), 0);
        chk("wd_pend", 32'(pending[2]), 0);
        acq_if.acq_ack = 1; step(); acq_if.acq_ack = 0;
        chk("wd_ack_ignored", 32'(busy), 0);
        cleanup();

        // Timeout
        ch_en = 5'b00001;
        pulse_tick(0);
        acq_if.acq_ack = 1; step(); acq_if.acq_ack = 0;
        seen = 0; pulses = 0;
        for (int c = 1; c <= 1100; c++) begin
            step();
            if (timeout_err) begin
                pulses++;
                if (seen == 0) seen = c;
            end
        end
        chk("tmo_cycles", 32'(seen), 1000);
        chk("tmo_pulses", 32'(pulses), 1);
        chk("tmo_idle", 32'(busy), 0);
        cleanup();

        // Async reset mid-BUSY
        ch_en = 5'b00100;
        pulse_tick(2);
        acq_if.acq_ack = 1; step(); acq_if.acq_ack = 0;
        tick_in[2] = 1; step();
        chk("rst_pre_busy", 32'(busy), 1);
        chk("rst_pre_pend", 32'(pending[2]), 1);
        #2; rst = 1; model_reset(); #1;
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_pend", 32'(pending), 0);
        chk("rst_async_ch", 32'(acq_if.acq_ch), 0);
        chk("rst_async_req", 32'(acq_if.acq_req), 0);
        step();
        tick_in[2] = 0; step();
        rst = 0;
        repeat (4) step();
        chk("rst_no_req", 32'(acq_if.acq_req), 0);
        pulse_tick(2);
        chk("rst_fresh_req", 32'(acq_if.acq_req), 1);
        cleanup();

        // Randomized traffic
        for (int i = 0; i < NCH; i++) begin
            half[i] = 1 + int'($urandom_range(7));
            hcnt[i] = half[i];
        end
        ch_en = 5'b11111;
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                hcnt[i]--;
                if (hcnt[i] == 0) begin
                    tick_in[i] = ~tick_in[i];
                    hcnt[i] = half[i];
                end
            end
            if ($urandom_range(63) == 0) ch_en = NCH'($urandom) | NCH'($urandom);
            acq_if.acq_ack  = (m_phase == PH_REQ)  ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            acq_if.acq_done = (m_phase == PH_BUSY) ? ($urandom_range(5) == 0) : ($urandom_range(19) == 0);
            ovr_sel = CH_W'($urandom_range(7));
            ovr_clr = ($urandom_range(31) == 0);
        end
        cleanup();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
